// File: rtl/pwl_pkg.sv
// Shared constants and helpers for the piecewise-linear activation unit.
// Pure combinational functions; no timing or backpressure of their own.
package pwl_pkg;

  localparam logic BANK_SIGMOID = 1'b0;
  localparam logic BANK_TANH    = 1'b1;

  // Widest index the helper below supports; callers zero-extend into it.
  localparam int PWL_IDX_MAX_W = 16;

  // Upper neighbour of a two's-complement index: -1 wraps to 0 and the
  // largest positive index saturates onto itself.
  function automatic logic [PWL_IDX_MAX_W-1:0] next_index(
    input logic [PWL_IDX_MAX_W-1:0] idx,
    input int unsigned              addr_w
  );
    logic [PWL_IDX_MAX_W-1:0] all_ones;
    logic [PWL_IDX_MAX_W-1:0] max_pos;
    all_ones = PWL_IDX_MAX_W'((32'd1 << addr_w) - 32'd1);
    max_pos  = PWL_IDX_MAX_W'((32'd1 << (addr_w - 1)) - 32'd1);
    if (idx == all_ones) begin
      return '0;
    end else if (idx == max_pos) begin
      return idx;
    end else begin
      return idx + PWL_IDX_MAX_W'(1);
    end
  endfunction

  function automatic int sat_signed(input int value, input int unsigned width);
    int lo;
    int hi;
    lo = -(32'sd1 <<< (width - 1));
    hi = (32'sd1 <<< (width - 1)) - 1;
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/pwl_activation_unit_if.sv
// Stream and config bundle for the piecewise-linear activation unit.
// Carries valid/ready on both sides; config writes have no handshake.
interface pwl_activation_unit_if #(
  parameter int ADDR_W = 4,
  parameter int FRAC_W = 4,
  parameter int DATA_W = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ADDR_W+FRAC_W-1:0]   in_data;
  logic                       in_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [DATA_W-1:0]   out_data;
  logic                       cfg_we;
  logic                       cfg_bank;
  logic [ADDR_W-1:0]          cfg_addr;
  logic signed [DATA_W-1:0]   cfg_data;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    output cfg_we, cfg_bank, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    input  cfg_we, cfg_bank, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pwl_table_bank.sv
// One activation table: register array, one write port, two async read ports.
// Reads are combinational (zero latency); writes land at the edge, never stall.
module pwl_table_bank #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr_base,
  input  logic [ADDR_W-1:0]        raddr_nxt,
  output logic signed [DATA_W-1:0] base,
  output logic signed [DATA_W-1:0] nxt
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Contents survive reset; only the write itself is suppressed while rst is high.
  always_comb begin
    mem_d = mem_q;
    if (we && !rst) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign base = $signed(mem_q[raddr_base]);
  assign nxt  = $signed(mem_q[raddr_nxt]);

endmodule

// File: rtl/pwl_activation_unit.sv
// Piecewise-linear sigmoid/tanh unit, rounding enabled by PWL_ROUND_EN; 3-cycle latency.
// Backpressure: whole pipe advances only when out is empty or taken; in_ready = advance.
module pwl_activation_unit
  import pwl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int FRAC_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pwl_activation_unit_if.slave  bus
);
  localparam int IN_W   = ADDR_W + FRAC_W;
  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DATA_W + FRAC_W + 2;
  localparam int SUM_W  = PROD_W + 1;
`ifdef PWL_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND = PROD_W'(2 ** (FRAC_W - 1));
`endif

  typedef struct packed {
    logic                     vld;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W-1:0] nxt;
    logic [FRAC_W-1:0]        frac;
  } s1_t;

  typedef struct packed {
    logic                     vld;
    logic signed [DATA_W-1:0] base;
    logic signed [PROD_W-1:0] prod;
  } s2_t;

  typedef struct packed {
    logic                     vld;
    logic signed [DATA_W-1:0] dat;
  } s3_t;

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;

  logic                     adv;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W-1:0]        nxt_idx;
  logic                     we_sig;
  logic                     we_tanh;
  logic signed [DATA_W-1:0] sig_base, sig_nxt;
  logic signed [DATA_W-1:0] tanh_base, tanh_nxt;
  logic signed [DATA_W-1:0] lk_base, lk_nxt;
  logic signed [DIFF_W-1:0] diff;
  logic signed [PROD_W-1:0] diff_x;
  logic signed [PROD_W-1:0] frac_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] rnd_prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [SUM_W-1:0]  sum;

  assign adv     = ~s3_q.vld | bus.out_ready;
  assign idx     = bus.in_data[IN_W-1 -: ADDR_W];
  assign nxt_idx = ADDR_W'(next_index(PWL_IDX_MAX_W'(idx), ADDR_W));
  assign we_sig  = bus.cfg_we && (bus.cfg_bank == BANK_SIGMOID);
  assign we_tanh = bus.cfg_we && (bus.cfg_bank == BANK_TANH);

  pwl_table_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank_sigmoid (
    .clk        (clk),
    .rst        (rst),
    .we         (we_sig),
    .waddr      (bus.cfg_addr),
    .wdata      (bus.cfg_data),
    .raddr_base (idx),
    .raddr_nxt  (nxt_idx),
    .base       (sig_base),
    .nxt        (sig_nxt)
  );

  pwl_table_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank_tanh (
    .clk        (clk),
    .rst        (rst),
    .we         (we_tanh),
    .waddr      (bus.cfg_addr),
    .wdata      (bus.cfg_data),
    .raddr_base (idx),
    .raddr_nxt  (nxt_idx),
    .base       (tanh_base),
    .nxt        (tanh_nxt)
  );

  assign lk_base = (bus.in_mode == BANK_TANH) ? tanh_base : sig_base;
  assign lk_nxt  = (bus.in_mode == BANK_TANH) ? tanh_nxt  : sig_nxt;

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;

    // Fraction is an unsigned weight, so it is zero-extended into the signed product.
    diff   = $signed({s1_q.nxt[DATA_W-1], s1_q.nxt}) - $signed({s1_q.base[DATA_W-1], s1_q.base});
    diff_x = PROD_W'(diff);
    frac_x = PROD_W'(s1_q.frac);
    prod   = diff_x * frac_x;

`ifdef PWL_ROUND_EN
    rnd_prod = s2_q.prod + RND;
`else
    rnd_prod = s2_q.prod;
`endif
    shifted = rnd_prod >>> FRAC_W;
    sum     = SUM_W'($signed(s2_q.base)) + SUM_W'(shifted);

    if (adv) begin
      s1_d = '{vld: bus.in_valid, base: lk_base, nxt: lk_nxt,
               frac: bus.in_data[FRAC_W-1:0]};
      s2_d = '{vld: s1_q.vld, base: s1_q.base, prod: prod};
      s3_d = '{vld: s2_q.vld, dat: DATA_W'(sat_signed(int'(sum), DATA_W))};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = s3_q.vld;
  assign bus.out_data  = s3_q.dat;

endmodule

// File: tb/tb_pwl_activation_unit.sv
// Directed plus randomized bench for pwl_activation_unit with an arithmetic reference model.
module tb_pwl_activation_unit;
  localparam int A    = 4;
  localparam int F    = 4;
  localparam int D    = 8;
  localparam int IN_W = A + F;
`ifdef PWL_ROUND_EN
  localparam int R_18 = 13;
  localparam int R_28 = 15;
`else
  localparam int R_18 = 12;
  localparam int R_28 = 14;
`endif

  logic clk;
  logic rst;

  pwl_activation_unit_if #(.ADDR_W(A), .FRAC_W(F), .DATA_W(D)) bus ();

  pwl_activation_unit #(.ADDR_W(A), .FRAC_W(F), .DATA_W(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int tbl [2][2**A];
  int exp_q [$];
  int n_out = 0;
  bit prev_stall = 0;
  int prev_dat = 0;

  int init0 [16] = '{8, 11, 14, 15, 15, 15, 15, 15, 0, 0, 0, 0, 0, 0, 1, 4};
  int init1 [16] = '{0, 25, 45, 55, 60, 62, 63, 63, -63, -63, -62, -60, -55, -45, -25, -10};
  logic [7:0] bp_dat [6] = '{8'h18, 8'hF8, 8'h7F, 8'h88, 8'h25, 8'h3C};

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: interpolate between the entry at the signed index and its
  // upper neighbour, using plain integer arithmetic.
  function automatic int model(input logic [IN_W-1:0] din, input logic mode);
    int idx, nidx, frac, b, n, p, r;
    idx  = $signed(din[IN_W-1 -: A]);
    frac = int'(din[F-1:0]);
    if (idx == -1)                 nidx = 0;
    else if (idx == 2**(A-1) - 1)  nidx = idx;
    else                           nidx = idx + 1;
    b = tbl[mode][idx & (2**A - 1)];
    n = tbl[mode][nidx & (2**A - 1)];
    p = (n - b) * frac;
`ifdef PWL_ROUND_EN
    p = p + 2**(F-1);
`endif
    r = b + (p >>> F);
    if (r > 2**(D-1) - 1) r = 2**(D-1) - 1;
    if (r < -(2**(D-1)))  r = -(2**(D-1));
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_vld", bus.out_valid, 1);
        check("hold_dat", bus.out_data, prev_dat);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("out_dat", bus.out_data, exp_q.pop_front());
        n_out++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) exp_q.push_back(model(bus.in_data, bus.in_mode));
      if (bus.cfg_we) tbl[bus.cfg_bank][bus.cfg_addr] = int'($signed(bus.cfg_data));
      prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      prev_dat   = int'($signed(bus.out_data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic bank, input int addr, input int val);
    bus.cfg_we   = 1'b1;
    bus.cfg_bank = bank;
    bus.cfg_addr = A'(addr);
    bus.cfg_data = D'(val);
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] d, input logic m, input int expv, input string tag);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check({tag, "_vld"}, bus.out_valid, 1);
    check(tag, bus.out_data, expv);
  endtask

  int  seen, stall_left, post, released, sent;
  bit  acc;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = 1'b0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_bank = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) cfg_write(1'b0, i, init0[i]);
    for (int i = 0; i < 16; i++) cfg_write(1'b1, i, init1[i]);

    lookup(8'h18, 1'b0, R_18, "interp");
    lookup(8'hF8, 1'b0, 6,    "wrap");
    lookup(8'h7F, 1'b0, 15,   "sat_top");
    lookup(8'h88, 1'b0, 0,    "most_neg");
    lookup(8'h28, 1'b1, 50,   "bank1");
    lookup(8'h28, 1'b0, R_28, "bank0_same_idx");
    step();

    // Write/lookup hazard on entry 1 of bank 0.
    bus.in_valid = 1'b1; bus.in_data = 8'h10; bus.in_mode = 1'b0; bus.out_ready = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_bank = 1'b0; bus.cfg_addr = 4'd1; bus.cfg_data = 8'sd20;
    step();
    bus.cfg_we = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    check("hazard_old", bus.out_data, 11);
    step();
    check("hazard_new_vld", bus.out_valid, 1);
    check("hazard_new", bus.out_data, 20);
    step();
    cfg_write(1'b0, 1, 11);
    repeat (3) step();

    // Backpressure: stall 5 cycles from the first result onwards.
    seen = 0; stall_left = 0; post = 0; released = 0; sent = 0;
    for (int c = 0; c < 60 && post < 6; c++) begin
      if (seen == 0 && bus.out_valid === 1'b1) begin
        seen = 1;
        stall_left = 5;
      end
      bus.out_ready = (stall_left == 0);
      bus.in_valid  = (sent < 6);
      bus.in_data   = bp_dat[(sent < 6) ? sent : 0];
      bus.in_mode   = 1'b0;
      @(negedge clk);
      if (stall_left > 0) begin
        check("bp_in_ready", bus.in_ready, 0);
        stall_left--;
        if (stall_left == 0) released = 1;
      end else if (released != 0) begin
        check("bp_no_gap", bus.out_valid, 1);
        post++;
      end
      acc = bus.in_valid && (bus.in_ready === 1'b1);
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_results", post, 6);
    check("bp_sent", sent, 6);
    repeat (3) step();

    // Reset with three samples in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = bp_dat[i];
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_stale_out", bus.out_valid, 0);
    end
    lookup(8'h18, 1'b0, R_18, "post_rst");
    step();

    // Randomized traffic with concurrent table writes.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = IN_W'($urandom);
      bus.in_mode   = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.cfg_we    = ($urandom_range(0, 7) == 0);
      bus.cfg_bank  = 1'($urandom);
      bus.cfg_addr  = A'($urandom);
      bus.cfg_data  = D'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) step();
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
